// File: rtl/wptr_full_level.sv
// wptr_full_level
// Write-clock-domain pointer and flag controller for a dual-clock FIFO.
// It advances the binary write address and publishes a Gray write pointer
// for the read-domain synchroniser. It compares the next write pointer with
// the already-synchronised Gray read pointer to derive registered full,
// almost-full and fill-level outputs, plus a sticky overflow flag.
//
// Optional feature macro: WPTR_LEVEL_EN
//   defined   -> registered wlevel output holds the occupancy 0..DEPTH
//   undefined -> no wlevel register; the wlevel port is tied to zero
module wptr_full_level #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_MARGIN = 1
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic                wovf,
  output logic [ADDRSIZE:0]   wlevel
);

  localparam int                DEPTH     = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_V   = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_THR = (ADDRSIZE+1)'(DEPTH - AFULL_MARGIN);

  logic                we;
  logic [ADDRSIZE:0]   wbin;
  logic [ADDRSIZE:0]   wbinnext;
  logic [ADDRSIZE:0]   wgraynext;
  logic [ADDRSIZE:0]   rbin_s;
  logic [ADDRSIZE:0]   used;
  logic [ADDRSIZE:0]   full_cmp;
  logic                wfull_val;
  logic                awfull_val;

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix XOR from the MSB down: each binary bit is the XOR of all Gray
  // bits at and above it.
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-pointer and flag evaluation; the current write and the sampled
  // read pointer are both folded into the same-cycle decision.
  always_comb begin
    we         = winc & ~wfull;
    wbinnext   = wbin + {{ADDRSIZE{1'b0}}, we};
    wgraynext  = bin2gray(wbinnext);
    rbin_s     = gray2bin(wq2_rptr);
    used       = wbinnext - rbin_s;
    // Full when the pointers differ only in the wrap bit: in Gray code that
    // means the top two bits are inverted and the rest match.
    full_cmp   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wfull_val  = (wgraynext == full_cmp);
    awfull_val = (used >= AFULL_THR);
  end

  assign waddr = wbin[ADDRSIZE-1:0];

  // Binary and Gray write pointers; the Gray copy is registered so the
  // read-domain synchroniser only ever sees single-bit changes.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin <= '0;
      wptr <= '0;
    end else begin
      wbin <= wbinnext;
      wptr <= wgraynext;
    end
  end

  // Registered full and almost-full flags.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wfull  <= 1'b0;
      awfull <= 1'b0;
    end else begin
      wfull  <= wfull_val;
      awfull <= awfull_val;
    end
  end

  // Sticky overflow: a write attempt while full sets it and beats a clear.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wovf <= 1'b0;
    end else if (winc & wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end

`ifdef WPTR_LEVEL_EN
  logic [ADDRSIZE:0] level_q;

  // Registered occupancy, taken from the same subtractor that drives awfull.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      level_q <= '0;
    end else begin
      level_q <= used;
    end
  end

  assign wlevel = level_q;
`else
  assign wlevel = '0;
`endif

  // Occupancy can never exceed the FIFO depth while the read pointer is legal.
  assert property (@(posedge wclk) disable iff (wrst) used <= DEPTH_V);

endmodule

// File: tb/tb_wptr_full_level.sv
// Scoreboard bench for wptr_full_level (ADDRSIZE=4, AFULL_MARGIN=1).
// Stimulus tasks push per-cycle expectations and hand-computed spot values;
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_wptr_full_level;

  localparam int D = 16;
  localparam int M = 1;

  logic       wclk     = 1'b0;
  logic       wrst     = 1'b1;
  logic       winc     = 1'b0;
  logic [4:0] wq2_rptr = 5'd0;
  logic       wovf_clr = 1'b0;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       awfull;
  logic       wovf;
  logic [4:0] wlevel;

  wptr_full_level #(.ADDRSIZE(4), .AFULL_MARGIN(M)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
    .wovf_clr(wovf_clr), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .awfull(awfull), .wovf(wovf), .wlevel(wlevel)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int cyc;
    int wptr;
    int waddr;
    int wfull;
    int awfull;
    int wovf;
    int wlevel;
  } exp_t;

  typedef struct {
    int    cyc;
    string name;
    int    field;
    int    val;
  } hand_t;

  exp_t  exp_q[$];
  hand_t hand_q[$];
  int    errors = 0;
  int    checks = 0;
  int    issued = 0;

  int m_wbin = 0, m_wfull = 0, m_awfull = 0, m_wovf = 0, m_wlevel = 0;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  // Reverse lookup rather than an XOR chain.
  function automatic int g2b(input int g);
    for (int i = 0; i < 32; i++) if (gray(i) == g) return i;
    return -1;
  endfunction

  function automatic int lvl(input int v);
`ifdef WPTR_LEVEL_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic logic [31:0] fld(input int f);
    case (f)
      0:       return {27'd0, wptr};
      1:       return {28'd0, waddr};
      2:       return {31'd0, wfull};
      3:       return {31'd0, awfull};
      4:       return {31'd0, wovf};
      default: return {27'd0, wlevel};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // One clock of stimulus; the model advances and its expectation is queued.
  task automatic step(input bit rst, input bit inc, input int rptr, input bit clr);
    int   nb;
    int   used;
    exp_t e;
    wrst = rst; winc = inc; wq2_rptr = 5'(rptr); wovf_clr = clr;
    @(posedge wclk);
    #1;
    if (rst) begin
      m_wbin = 0; m_wfull = 0; m_awfull = 0; m_wovf = 0; m_wlevel = 0;
    end else begin
      nb       = (m_wbin + ((inc && m_wfull == 0) ? 1 : 0)) % 32;
      used     = (nb - g2b(rptr) + 32) % 32;
      m_wovf   = (inc && m_wfull != 0) ? 1 : (clr ? 0 : m_wovf);
      m_wfull  = (used == D) ? 1 : 0;
      m_awfull = (used >= D - M) ? 1 : 0;
      m_wlevel = lvl(used);
      m_wbin   = nb;
    end
    issued++;
    e.cyc = issued; e.wptr = gray(m_wbin); e.waddr = m_wbin % 16;
    e.wfull = m_wfull; e.awfull = m_awfull; e.wovf = m_wovf; e.wlevel = m_wlevel;
    exp_q.push_back(e);
  endtask

  task automatic hand(input string nm, input int field, input int val);
    hand_t h;
    h.cyc = issued; h.name = nm; h.field = field; h.val = val;
    hand_q.push_back(h);
  endtask

  exp_t  cur;
  hand_t hc;

  // Monitor: compare the model and any hand values for the cycle just clocked.
  always @(negedge wclk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("wptr",   fld(0), cur.wptr);
      chk("waddr",  fld(1), cur.waddr);
      chk("wfull",  fld(2), cur.wfull);
      chk("awfull", fld(3), cur.awfull);
      chk("wovf",   fld(4), cur.wovf);
      chk("wlevel", fld(5), cur.wlevel);
      while (hand_q.size() > 0 && hand_q[0].cyc <= cur.cyc) begin
        hc = hand_q.pop_front();
        chk(hc.name, fld(hc.field), hc.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles with winc high
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    hand("rst_wptr", 0, 0);  hand("rst_waddr", 1, 0); hand("rst_wfull", 2, 0);
    hand("rst_awfull", 3, 0); hand("rst_wovf", 4, 0); hand("rst_wlevel", 5, 0);

    // Fill 16 entries against an idle reader
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 0);
      if (i == 14) hand("fill14_awfull", 3, 0);
      if (i == 15) begin
        hand("fill15_awfull", 3, 1); hand("fill15_wfull", 2, 0);
        hand("fill15_wlevel", 5, lvl(15));
      end
      if (i == 16) begin
        hand("fill16_wfull", 2, 1); hand("fill16_wptr", 0, 24);
        hand("fill16_waddr", 1, 0); hand("fill16_wlevel", 5, lvl(16));
      end
    end

    // Writes while full are dropped and set overflow
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      hand("ovf_wptr", 0, 24); hand("ovf_waddr", 1, 0); hand("ovf_wovf", 4, 1);
    end
    step(0, 1, 0, 1);
    hand("ovf_set_beats_clr", 4, 1); hand("ovf_clr_wptr", 0, 24);
    step(0, 0, 0, 1);
    hand("ovf_clr", 4, 0);

    // Reader frees one slot, then one more write refills
    step(0, 0, 1, 0);
    hand("rel_wfull", 2, 0); hand("rel_awfull", 3, 1); hand("rel_wlevel", 5, lvl(15));
    step(0, 1, 1, 0);
    hand("refull_wfull", 2, 1); hand("refull_wptr", 0, 25);
    hand("refull_waddr", 1, 1); hand("refull_wlevel", 5, lvl(16));
    step(0, 1, 1, 0);
    hand("refull_ovf", 4, 1);

    // Reset in mid-operation with winc high
    step(1, 1, 0, 0);
    hand("mrst_wptr", 0, 0); hand("mrst_wfull", 2, 0); hand("mrst_awfull", 3, 0);
    hand("mrst_wovf", 4, 0); hand("mrst_wlevel", 5, 0);

    // Wrap: reader trails the writer by two entries
    step(0, 0, gray(30), 0);
    hand("wrap_pre_wlevel", 5, lvl(2));
    for (int i = 1; i <= 33; i++) begin
      step(0, 1, gray((i - 2 + 32) % 32), 0);
      hand("wrap_wfull", 2, 0); hand("wrap_wlevel", 5, lvl(2));
      if (i == 31) hand("wrap31_wptr", 0, 16);
      if (i == 32) begin
        hand("wrap32_wptr", 0, 0); hand("wrap32_waddr", 1, 0);
      end
    end

    winc = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    checks++;
    if (exp_q.size() != 0 || hand_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size() + hand_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
